// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: states, instruction encodings and decode helper for rv_ctrl_mc
package rv_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {I_BAD, I_LD, I_SD, I_ADDI, I_ADD, I_SUB, I_BEQ} instr_t;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_D = 3'b011;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;
    localparam logic [31:0] HALT_INSTR = 32'h0000_0073;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    function automatic instr_t decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        return (opc == OPC_LOAD && f3 == F3_D) ? I_LD :
               (opc == OPC_STORE && f3 == F3_D) ? I_SD :
               (opc == OPC_IMM && f3 == F3_ADD) ? I_ADDI :
               (opc == OPC_REG && f3 == F3_ADD && f7 == F7_ADD) ? I_ADD :
               (opc == OPC_REG && f3 == F3_ADD && f7 == F7_SUB) ? I_SUB :
               (opc == OPC_BRANCH && f3 == F3_BEQ) ? I_BEQ : I_BAD;
    endfunction
endpackage

// File: rtl/rv_ctrl_if.sv
// rv_ctrl_if: control unit inputs and datapath/memory steering signals
interface rv_ctrl_if;
    logic start;
    logic [31:0] instr;
    logic alu_zero;
    logic imem_re;
    logic [31:0] ir_q;
    logic [4:0] Ra;
    logic [4:0] Rb;
    logic [4:0] Rw;
    logic WE_Reg;
    logic [63:0] imm;
    logic alu_src;
    logic [1:0] alu_op;
    logic mem_re;
    logic mem_we;
    logic wb_sel;
    logic pc_load;
    logic pc_src;
    logic halted;
    logic illegal;
    modport master (
        input start, instr, alu_zero,
        output imem_re, ir_q, Ra, Rb, Rw, WE_Reg, imm, alu_src, alu_op,
        mem_re, mem_we, wb_sel, pc_load, pc_src, halted, illegal
    );
    modport slave (
        output start, instr, alu_zero,
        input imem_re, ir_q, Ra, Rb, Rw, WE_Reg, imm, alu_src, alu_op,
        mem_re, mem_we, wb_sel, pc_load, pc_src, halted, illegal
    );
endinterface

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: sign-extended I/S/B immediate from the instruction register fields
module rv_imm_gen
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [11:0] imm_hi,
    input  logic [4:0]  imm_lo,
    output logic [63:0] imm
);
    always_comb begin
        imm = (opcode == OPC_LOAD || opcode == OPC_IMM) ? {{52{imm_hi[11]}}, imm_hi} :
              (opcode == OPC_STORE) ? {{52{imm_hi[11]}}, imm_hi[11:5], imm_lo} :
              (opcode == OPC_BRANCH) ? {{52{imm_hi[11]}}, lo_bit(imm_lo), imm_hi[10:5], imm_lo[4:1], 1'b0} :
              64'd0;
    end
    function automatic logic lo_bit(input logic [4:0] lo);
        return lo[0];
    endfunction
endmodule

// File: rtl/rv_ctrl_mc.sv
// rv_ctrl_mc: multicycle RV64I-subset control unit sequencing FETCH/DECODE/EXEC/MEM/WB
module rv_ctrl_mc
    import rv_ctrl_pkg::*;
(
    input logic clk,
    input logic rst,
    rv_ctrl_if.master bus
);
    state_t state, state_n;
    logic [31:0] ir_q;
    logic illegal_q;
    instr_t op;
    assign op = decode(ir_q[6:0], ir_q[14:12], ir_q[31:25]);
    assign bus.ir_q = ir_q;
    assign bus.Ra = ir_q[19:15];
    assign bus.Rb = ir_q[24:20];
    assign bus.Rw = ir_q[11:7];
    assign bus.halted = state == S_HALT;
    assign bus.illegal = illegal_q;
    rv_imm_gen u_imm (
        .opcode(ir_q[6:0]),
        .imm_hi(ir_q[31:20]),
        .imm_lo(ir_q[11:7]),
        .imm(bus.imm)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ir_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_FETCH) ir_q <= bus.instr;
            if (state == S_DECODE && op == I_BAD) illegal_q <= ir_q != HALT_INSTR;
            else if (state == S_HALT && bus.start) illegal_q <= 1'b0;
        end
    end
    always_comb begin
        state_n = state;
        bus.imem_re = 1'b0;
        bus.WE_Reg = 1'b0;
        bus.alu_src = 1'b0;
        bus.alu_op = ALU_ADD;
        bus.mem_re = 1'b0;
        bus.mem_we = 1'b0;
        bus.wb_sel = 1'b0;
        bus.pc_load = 1'b0;
        bus.pc_src = 1'b0;
        case (state)
            S_IDLE: state_n = bus.start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                bus.imem_re = 1'b1;
                state_n = S_DECODE;
            end
            S_DECODE: state_n = (op == I_BAD) ? S_HALT : S_EXEC;
            S_EXEC: begin
                bus.alu_op = (op == I_SUB || op == I_BEQ) ? ALU_SUB : ALU_ADD;
                bus.alu_src = op == I_LD || op == I_SD || op == I_ADDI;
                bus.pc_load = op == I_BEQ;
                bus.pc_src = op == I_BEQ && bus.alu_zero;
                state_n = (op == I_BEQ) ? S_FETCH : (op == I_LD || op == I_SD) ? S_MEM : S_WB;
            end
            S_MEM: begin
                bus.mem_re = op == I_LD;
                bus.mem_we = op == I_SD;
                bus.pc_load = op == I_SD;
                state_n = (op == I_LD) ? S_WB : S_FETCH;
            end
            S_WB: begin
                bus.WE_Reg = ir_q[11:7] != 5'd0;
                bus.wb_sel = op == I_LD;
                bus.pc_load = 1'b1;
                state_n = S_FETCH;
            end
            S_HALT: state_n = bus.start ? S_FETCH : S_HALT;
            default: state_n = S_IDLE;
        endcase
    end
endmodule
